// File: rtl/intra_mode_sched.sv
// intra_mode_sched: sweeps every legal intra mode through the reconstruct adder, keeps the
// cheapest mode by reported cost, then re-issues the winner so reconst holds its result.
module intra_mode_sched #(
  parameter int unsigned MB_SIZE_L = 16,
  parameter int unsigned COST_W    = 16,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              pa_enable,
  output logic [2:0]        pa_mode,
  input  logic              cost_valid,
  input  logic [COST_W-1:0] cost,
  output logic              busy,
  output logic              done,
  output logic [2:0]        best_mode,
  output logic [COST_W-1:0] best_cost,
  output logic              error
);

  localparam int unsigned NUM_MODES = (MB_SIZE_L == 4) ? 8 : 3;
  localparam int unsigned TMO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0]       LastMode = 3'(NUM_MODES - 1);
  localparam logic [TMO_W-1:0] TmoMax   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitCost, StFinal, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        m_q, m_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        pa_mode_d, best_mode_d;
  logic [COST_W-1:0] best_cost_d;
  logic              error_d;

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    tmo_d       = tmo_q;
    pa_mode_d   = pa_mode;
    best_mode_d = best_mode;
    best_cost_d = best_cost;
    error_d     = error;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StIssue;
            m_d         = '0;
            tmo_d       = '0;
            pa_mode_d   = '0;
            best_mode_d = '0;
            best_cost_d = '1;
            error_d     = 1'b0;
          end
        end
        StIssue: state_d = StWaitCost;
        StWaitCost: begin
          if (cost_valid || (tmo_q == TmoMax)) begin
            // A timed-out cost counts as all-ones, so it can never win a strict compare.
            if (!cost_valid) begin
              error_d = 1'b1;
            end else if (cost < best_cost) begin
              best_cost_d = cost;
              best_mode_d = m_q;
            end
            if (m_q != LastMode) begin
              m_d       = m_q + 3'd1;
              tmo_d     = '0;
              pa_mode_d = m_q + 3'd1;
              state_d   = StIssue;
            end else if (best_mode_d == LastMode) begin
              // Adder already holds the winner's reconstruction.
              state_d = StDone;
            end else begin
              pa_mode_d = best_mode_d;
              state_d   = StFinal;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        StFinal: state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      m_q       <= '0;
      tmo_q     <= '0;
      pa_enable <= 1'b0;
      pa_mode   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_mode <= '0;
      best_cost <= '0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      tmo_q     <= tmo_d;
      pa_enable <= (state_d == StIssue) || (state_d == StFinal);
      pa_mode   <= pa_mode_d;
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      best_mode <= best_mode_d;
      best_cost <= best_cost_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_intra_mode_sched.sv
// Bench for intra_mode_sched: one 4x4 and one 16x16 instance driven open-loop from a sweep
// plan; a per-sweep timeline model gives the expected outputs for every cycle.
module tb_intra_mode_sched;

  localparam int TIMEOUT = 15;
  localparam int MAXI    = 200;

  logic        clk, reset, abort, cost_valid, start4, start16;
  logic [15:0] cost;
  logic        pa_enable4, busy4, done4, error4;
  logic        pa_enable16, busy16, done16, error16;
  logic [2:0]  pa_mode4, best_mode4, pa_mode16, best_mode16;
  logic [15:0] best_cost4, best_cost16;

  intra_mode_sched #(.MB_SIZE_L(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort),
    .pa_enable(pa_enable4), .pa_mode(pa_mode4), .cost_valid(cost_valid), .cost(cost),
    .busy(busy4), .done(done4), .best_mode(best_mode4), .best_cost(best_cost4),
    .error(error4)
  );

  intra_mode_sched #(.MB_SIZE_L(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .abort(abort),
    .pa_enable(pa_enable16), .pa_mode(pa_mode16), .cost_valid(cost_valid), .cost(cost),
    .busy(busy16), .done(done16), .best_mode(best_mode16), .best_cost(best_cost16),
    .error(error16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sweep plan and expected timeline (index = cycles since the start-sampling edge)
  logic [15:0] plan_cost [8];
  int          plan_lat  [8];
  logic        e_en [MAXI], e_busy [MAXI], e_done [MAXI], e_err [MAXI], in_wait [MAXI];
  logic [2:0]  e_md [MAXI], e_bm [MAXI];
  logic [15:0] e_bc [MAXI];
  int          resp_mode [MAXI];
  int          done_r, nint, cur_r, dut_done_r;
  logic        chk_en, sel;

  task automatic put(input int r, input logic en, input logic [2:0] md, input logic bz,
                     input logic dn, input logic [2:0] bm, input logic [15:0] bc,
                     input logic er);
    e_en[r] = en; e_md[r] = md; e_busy[r] = bz; e_done[r] = dn;
    e_bm[r] = bm; e_bc[r] = bc; e_err[r] = er;
  endtask

  task automatic build_model(input int nm);
    int r, w;
    logic [2:0]  bm;
    logic [15:0] bc;
    logic        er;
    bm = 3'd0; bc = 16'hFFFF; er = 1'b0; r = 0;
    for (int i = 0; i < MAXI; i++) begin
      resp_mode[i] = -1;
      in_wait[i] = 1'b0;
    end
    for (int k = 0; k < nm; k++) begin
      put(r, 1'b1, 3'(k), 1'b1, 1'b0, bm, bc, er);
      r++;
      w = (plan_lat[k] <= TIMEOUT) ? plan_lat[k] + 1 : TIMEOUT + 1;
      for (int j = 0; j < w; j++) begin
        put(r, 1'b0, 3'(k), 1'b1, 1'b0, bm, bc, er);
        in_wait[r] = 1'b1;
        if (j == plan_lat[k]) resp_mode[r] = k;
        r++;
      end
      if (plan_lat[k] > TIMEOUT) er = 1'b1;
      else if (plan_cost[k] < bc) begin
        bc = plan_cost[k];
        bm = 3'(k);
      end
    end
    if (int'(bm) != nm - 1) begin
      put(r, 1'b1, bm, 1'b1, 1'b0, bm, bc, er);
      r++;
    end
    put(r, 1'b0, bm, 1'b1, 1'b1, bm, bc, er);
    done_r = r;
    put(r + 1, 1'b0, bm, 1'b0, 1'b0, bm, bc, er);
    nint = r + 2;
  endtask

  // Abort sampled at the end of cycle a: idle next cycle, results frozen as of cycle a.
  task automatic apply_abort(input int a);
    if (a >= 0 && a < done_r) begin
      put(a + 1, 1'b0, e_md[a], 1'b0, 1'b0, e_bm[a], e_bc[a], e_err[a]);
      nint = a + 2;
      done_r = -1;
    end
  endtask

  logic        a_en, a_busy, a_done, a_err;
  logic [2:0]  a_md, a_bm;
  logic [15:0] a_bc;
  assign a_en   = sel ? pa_enable16 : pa_enable4;
  assign a_busy = sel ? busy16 : busy4;
  assign a_done = sel ? done16 : done4;
  assign a_err  = sel ? error16 : error4;
  assign a_md   = sel ? pa_mode16 : pa_mode4;
  assign a_bm   = sel ? best_mode16 : best_mode4;
  assign a_bc   = sel ? best_cost16 : best_cost4;

  always @(negedge clk) begin
    if (chk_en) begin
      check("pa_enable", 32'(a_en), 32'(e_en[cur_r]));
      if (e_en[cur_r] || (in_wait[cur_r] && e_busy[cur_r]))
        check("pa_mode", 32'(a_md), 32'(e_md[cur_r]));
      check("busy", 32'(a_busy), 32'(e_busy[cur_r]));
      check("done", 32'(a_done), 32'(e_done[cur_r]));
      check("best_mode", 32'(a_bm), 32'(e_bm[cur_r]));
      check("best_cost", 32'(a_bc), 32'(e_bc[cur_r]));
      check("error", 32'(a_err), 32'(e_err[cur_r]));
      if (a_done) dut_done_r = cur_r;
    end
  end

  // abort_at: -1 none, -2 random choice, else the cycle in which abort is driven.
  task automatic run_sweep(input logic s, input int abort_in);
    int abort_at;
    abort_at = abort_in;
    build_model(s ? 3 : 8);
    if (abort_at == -2)
      abort_at = ($urandom % 5 == 0) ? int'($urandom_range(0, done_r - 1)) : -1;
    apply_abort(abort_at);
    sel = s;
    dut_done_r = -1;
    @(posedge clk); #1;
    abort = 1'b0; cost_valid = 1'b0; cost = '0;
    if (s) start16 = 1'b1; else start4 = 1'b1;
    for (int r = 0; r < nint; r++) begin
      @(posedge clk); #1;
      start4 = 1'b0; start16 = 1'b0;
      cur_r = r; chk_en = 1'b1;
      abort = (r == abort_at);
      if (resp_mode[r] >= 0) begin
        cost_valid = 1'b1; cost = plan_cost[resp_mode[r]];
      end else if (in_wait[r]) begin
        cost_valid = 1'b0; cost = 16'($urandom);
      end else begin
        // A zero cost would win if latched outside the cost window.
        cost_valid = 1'($urandom); cost = '0;
      end
      if (e_busy[r] && ($urandom % 3 == 0)) begin
        if (s) start16 = 1'b1; else start4 = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk_en = 1'b0; start4 = 1'b0; start16 = 1'b0; abort = 1'b0; cost_valid = 1'b0;
  endtask

  initial begin
    chk_en = 1'b0; sel = 1'b0; cur_r = 0; dut_done_r = -1;
    start4 = 1'b0; start16 = 1'b0; abort = 1'b0; cost_valid = 1'b0; cost = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pa_enable4", 32'(pa_enable4), 0);  check("rst_pa_enable16", 32'(pa_enable16), 0);
    check("rst_pa_mode4", 32'(pa_mode4), 0);      check("rst_pa_mode16", 32'(pa_mode16), 0);
    check("rst_busy4", 32'(busy4), 0);            check("rst_busy16", 32'(busy16), 0);
    check("rst_done4", 32'(done4), 0);            check("rst_done16", 32'(done16), 0);
    check("rst_best_mode4", 32'(best_mode4), 0);  check("rst_best_mode16", 32'(best_mode16), 0);
    check("rst_best_cost4", 32'(best_cost4), 0);  check("rst_best_cost16", 32'(best_cost16), 0);
    check("rst_error4", 32'(error4), 0);          check("rst_error16", 32'(error16), 0);
    reset = 1'b1;

    // 4x4, distinct costs: mode 4 wins, FINAL re-issues it
    plan_cost = '{16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd60, 16'd70, 16'd80};
    plan_lat  = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_sweep(1'b0, -1);
    check("t1_model_done", done_r, 17);
    check("t1_done_cycle", dut_done_r, 17);
    check("t1_best_mode", 32'(best_mode4), 4);
    check("t1_best_cost", 32'(best_cost4), 10);
    check("t1_error", 32'(error4), 0);

    // 16x16, last mode wins: no FINAL
    plan_cost = '{16'd100, 16'd100, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_sweep(1'b1, -1);
    check("t2_done_cycle", dut_done_r, 6);
    check("t2_best_mode", 32'(best_mode16), 2);
    check("t2_best_cost", 32'(best_cost16), 5);

    // 16x16, tie keeps lower mode
    plan_cost = '{16'd7, 16'd7, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_sweep(1'b1, -1);
    check("t3_done_cycle", dut_done_r, 7);
    check("t3_best_mode", 32'(best_mode16), 0);
    check("t3_best_cost", 32'(best_cost16), 7);

    // 16x16, mode 1 never answers
    plan_cost = '{16'd20, 16'd1, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    plan_lat  = '{0, 99, 0, 0, 0, 0, 0, 0};
    run_sweep(1'b1, -1);
    check("t4_done_cycle", dut_done_r, 22);
    check("t4_error", 32'(error16), 1);
    check("t4_best_mode", 32'(best_mode16), 0);
    plan_lat  = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_sweep(1'b1, -1);
    check("t4_error_cleared", 32'(error16), 0);

    // 4x4, abort in mode 3's cost wait
    plan_cost = '{16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd60, 16'd70, 16'd80};
    run_sweep(1'b0, 7);
    check("t5_no_done", dut_done_r, -1);
    check("t5_idle", 32'(busy4), 0);

    // Asynchronous reset during ISSUE of mode 1
    cost_valid = 1'b1; cost = 16'd5; abort = 1'b0;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check("t6_pre_reset_enable", 32'(pa_enable4), 1);
    reset = 1'b0;
    #1;
    check("t6_pa_enable", 32'(pa_enable4), 0);
    check("t6_busy", 32'(busy4), 0);
    check("t6_done", 32'(done4), 0);
    check("t6_pa_mode", 32'(pa_mode4), 0);
    check("t6_best_mode", 32'(best_mode4), 0);
    check("t6_best_cost", 32'(best_cost4), 0);
    check("t6_error", 32'(error4), 0);
    @(posedge clk); #1;
    check("t6_held_busy", 32'(busy4), 0);
    reset = 1'b1; cost_valid = 1'b0;
    run_sweep(1'b0, -1);
    check("t6_restart_done", dut_done_r, 17);

    // Randomized sweeps
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 8; k++) begin
        plan_cost[k] = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
        plan_lat[k]  = ($urandom % 8 == 0) ? 99 : int'($urandom_range(0, 3));
      end
      run_sweep(1'($urandom), -2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
